// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - 4-entry direct-mapped branch target buffer with 2-bit counters
module branch_target_buffer #(
  parameter logic [1:0] ALLOC_STATE = 2'b10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output logic        btb_taken,
  output logic [31:0] btb_target,
  output logic [1:0]  btb_index,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  // Counter encodings: predict taken only when the MSB is set (WT/ST).
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [3:0]  valid;
  logic [27:0] tag [4];
  logic [31:0] tgt [4];
  logic [1:0]  ctr [4];

  logic [1:0]  lk_idx;
  logic        lk_hit;
  logic [1:0]  up_idx;
  logic        up_hit;

  // Byte-offset bits of both PCs are never used: instructions are word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[3:2];
  assign up_idx = upd_pc[3:2];

  // Zero-cycle lookup: reads stored state directly, so an update on this
  // edge only becomes visible to the lookup in the following cycle.
  always_comb begin
    lk_hit     = valid[lk_idx] && (tag[lk_idx] == lookup_pc[31:4]);
    btb_index  = lk_idx;
    btb_taken  = lk_hit && ctr[lk_idx][1];
    btb_target = btb_taken ? tgt[lk_idx] : (lookup_pc + 32'd4);
  end

  // Update-side tag match for the resolved branch.
  always_comb begin
    up_hit = valid[up_idx] && (tag[up_idx] == upd_pc[31:4]);
  end

  // Table state: reset wins over any update on the same edge; hits train the
  // saturating counter, taken misses allocate (evicting any previous owner).
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        tgt[i]   <= '0;
        ctr[i]   <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr[up_idx] != CTR_ST) begin
            ctr[up_idx] <= ctr[up_idx] + 2'd1;
          end
          tgt[up_idx] <= upd_target;
        end else if (ctr[up_idx] != CTR_SNT) begin
          ctr[up_idx] <= ctr[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid[up_idx] <= 1'b1;
        tag[up_idx]   <= upd_pc[31:4];
        tgt[up_idx]   <= upd_target;
        ctr[up_idx]   <= ALLOC_STATE;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - table-driven scoreboard bench for branch_target_buffer
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic [1:0]  btb_index;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  branch_target_buffer #(.ALLOC_STATE(2'b10)) dut (
    .CLK        (clk),
    .RST        (rst),
    .lookup_pc  (lookup_pc),
    .btb_taken  (btb_taken),
    .btb_target (btb_target),
    .btb_index  (btb_index),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic [31:0] lpc;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic [1:0]  exp_index;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [1:0]  index;
    int          id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass;
  int   n_total;
  int   step_id;

  function automatic vec_t mk(logic r, logic en, logic [31:0] upc, logic utk,
                              logic [31:0] utgt, logic [31:0] lpc,
                              logic et, logic [31:0] etgt, logic [1:0] eidx);
    vec_t v;
    v.rst = r; v.en = en; v.upc = upc; v.utk = utk; v.utgt = utgt;
    v.lpc = lpc; v.exp_taken = et; v.exp_target = etgt; v.exp_index = eidx;
    return v;
  endfunction

  task automatic check32(string name, int id, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
  endtask

  // Called at a falling edge: drive one cycle of stimulus, queue the expected
  // lookup result, sample mid-cycle before the next rising edge, then move on.
  task automatic step(vec_t v);
    exp_t e;
    exp_t got;
    rst        = v.rst;
    upd_en     = v.en;
    upd_pc     = v.upc;
    upd_taken  = v.utk;
    upd_target = v.utgt;
    lookup_pc  = v.lpc;
    e.taken  = v.exp_taken;
    e.target = v.exp_target;
    e.index  = v.exp_index;
    e.id     = step_id;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", step_id);
    end else begin
      got = sb.pop_front();
      check32("btb_taken",  got.id, {31'd0, btb_taken}, {31'd0, got.taken});
      check32("btb_target", got.id, btb_target, got.target);
      check32("btb_index",  got.id, {30'd0, btb_index}, {30'd0, got.index});
    end
    step_id++;
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; n_pass = 0; n_total = 0; step_id = 0;
    rst = 1'b1; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; lookup_pc = '0;

    //        rst en  upd_pc        tk  upd_target    lookup_pc     et  exp_target    idx
    // cold miss and allocation
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h40,       0, 32'h44,       2'd0));
    tbl.push_back(mk(0, 1, 32'h44,       1, 32'h100,   32'h44,       0, 32'h48,       2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h44,       1, 32'h100,      2'd1));
    // hysteresis 10->01->00 (hold) ->01->10
    tbl.push_back(mk(0, 1, 32'h44,       0, 32'h0,     32'h44,       1, 32'h100,      2'd1));
    tbl.push_back(mk(0, 1, 32'h44,       0, 32'h0,     32'h44,       0, 32'h48,       2'd1));
    tbl.push_back(mk(0, 1, 32'h44,       0, 32'h0,     32'h44,       0, 32'h48,       2'd1));
    tbl.push_back(mk(0, 1, 32'h44,       1, 32'h100,   32'h44,       0, 32'h48,       2'd1));
    tbl.push_back(mk(0, 1, 32'h44,       1, 32'h104,   32'h44,       0, 32'h48,       2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h44,       1, 32'h104,      2'd1));
    // upper saturation 10->11->11->10, still taken
    tbl.push_back(mk(0, 1, 32'h44,       1, 32'h104,   32'h44,       1, 32'h104,      2'd1));
    tbl.push_back(mk(0, 1, 32'h44,       1, 32'h104,   32'h44,       1, 32'h104,      2'd1));
    tbl.push_back(mk(0, 1, 32'h44,       0, 32'h0,     32'h44,       1, 32'h104,      2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h44,       1, 32'h104,      2'd1));
    // aliasing and eviction
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h54,       0, 32'h58,       2'd1));
    tbl.push_back(mk(0, 1, 32'h54,       1, 32'h200,   32'h44,       1, 32'h104,      2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h44,       0, 32'h48,       2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h54,       1, 32'h200,      2'd1));
    // not-taken miss does not allocate
    tbl.push_back(mk(0, 1, 32'h60,       0, 32'h300,   32'h60,       0, 32'h64,       2'd0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h60,       0, 32'h64,       2'd0));
    // upd_en=0 ignores would-be decrement and would-be allocation
    tbl.push_back(mk(0, 0, 32'h54,       0, 32'h0,     32'h54,       1, 32'h200,      2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h54,       1, 32'h200,      2'd1));
    tbl.push_back(mk(0, 0, 32'h70,       1, 32'h400,   32'h70,       0, 32'h74,       2'd0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h70,       0, 32'h74,       2'd0));
    // same-cycle read/write on the allocated entry
    tbl.push_back(mk(0, 1, 32'h48,       1, 32'h500,   32'h48,       0, 32'h4C,       2'd2));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h48,       1, 32'h500,      2'd2));
    // pc+4 wraps modulo 2^32
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'hFFFFFFFC, 0, 32'h0,        2'd3));
    // allocation lands in WT: one not-taken drops prediction
    tbl.push_back(mk(0, 1, 32'h54,       0, 32'h0,     32'h54,       1, 32'h200,      2'd1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,     32'h54,       0, 32'h58,       2'd1));

    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset mid-operation with a simultaneous allocating update: the lookup
    // during the reset cycle still sees old contents, afterwards all miss.
    step(mk(1, 1, 32'h6C, 1, 32'h600, 32'h48,       1, 32'h500, 2'd2));
    step(mk(0, 0, 32'h0,  0, 32'h0,   32'h48,       0, 32'h4C,  2'd2));
    step(mk(0, 0, 32'h0,  0, 32'h0,   32'h6C,       0, 32'h70,  2'd3));
    step(mk(0, 0, 32'h0,  0, 32'h0,   32'h54,       0, 32'h58,  2'd1));
    // tag 0 equals the cleared tag, but the entry is invalid
    step(mk(0, 0, 32'h0,  0, 32'h0,   32'h0,        0, 32'h4,   2'd0));
    // a not-taken update after reset must not train an invalid entry
    step(mk(0, 1, 32'h4,  0, 32'h0,   32'h4,        0, 32'h8,   2'd1));
    step(mk(0, 1, 32'h4,  1, 32'h700, 32'h4,        0, 32'h8,   2'd1));
    step(mk(0, 0, 32'h0,  0, 32'h0,   32'h4,        1, 32'h700, 2'd1));

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
